// File: rtl/powlib_busfifo_pkg.sv
//------------------------------------------------------------------------------
// powlib_busfifo_pkg
//
// Purpose: shared helpers for the bus FIFO slice.
//   - powlib_clogb2: ceiling log2, used to size pointers and occupancy
//     counters from a depth parameter.
//
// Ports: none (package).
//------------------------------------------------------------------------------
package powlib_busfifo_pkg;

    // Smallest number of bits needed to index 'value' distinct items.
    // For example, 8 gives 3 and 9 gives 4. A value of 0 or 1 gives 0, so
    // callers keep their arguments at 2 or more.
    function automatic int powlib_clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage : powlib_busfifo_pkg

// File: rtl/powlib_dpram.sv
//------------------------------------------------------------------------------
// powlib_dpram
//
// Purpose: simple dual-port RAM used as FIFO storage. One port writes
// synchronously with a per-bit write enable. The other port reads
// asynchronously, so the read data follows the read address in the same
// cycle. The contents are not reset.
//
// Ports:
//   clk     in   1    rising-edge clock for the write port
//   wraddr  in   AW   write address
//   wrdata  in   W    write data
//   wrbe    in   W    per-bit write enable (1 = bit is written)
//   rdaddr  in   AW   read address
//   rddata  out  W    read data (combinational from rdaddr)
//------------------------------------------------------------------------------
module powlib_dpram
    import powlib_busfifo_pkg::*;
#(
    parameter string ID = "DPRAM",
    parameter int    W  = 32,
    parameter int    D  = 8,
    parameter int    AW = powlib_clogb2(D)
) (
    input  logic          clk,
    input  logic [AW-1:0] wraddr,
    input  logic [W-1:0]  wrdata,
    input  logic [W-1:0]  wrbe,
    input  logic [AW-1:0] rdaddr,
    output logic [W-1:0]  rddata
);

    // An empty memory or a zero-width word makes no sense, so the build is
    // stopped with the instance name.
    if (D < 1 || W < 1) begin : g_cfg_error
        $error("%s: invalid RAM configuration W=%0d D=%0d", ID, W, D);
    end

    logic [W-1:0] mem [D];

    // Write port. Only the bits selected by wrbe are updated. The other bits
    // of the addressed word keep their old value, so an all-zero enable
    // leaves the memory unchanged.
    always_ff @(posedge clk) begin
        mem[wraddr] <= (mem[wraddr] & ~wrbe) | (wrdata & wrbe);
    end

    // Read port. It is asynchronous, so the FIFO head is visible in the same
    // cycle that the read pointer points at it.
    assign rddata = mem[rdaddr];

endmodule : powlib_dpram

// File: rtl/powlib_busfifo.sv
//------------------------------------------------------------------------------
// powlib_busfifo
//
// Purpose: single-clock, first-word-fall-through bus FIFO. Each entry holds an
// address word and a data word. Both sides use a valid/ready handshake. A
// programmable nearly-full flag lets upstream pipelines stall early. Storage
// is a powlib_dpram; all control logic is in this module.
//
// Ports:
//   clk     in   1     rising-edge clock
//   rst     in   1     asynchronous, active-low reset
//   wraddr  in   B_AW  write-side address
//   wrdata  in   B_DW  write-side data
//   wrvld   in   1     write request
//   wrrdy   out  1     FIFO not full
//   wrnf    out  1     nearly full: free entries <= NFS
//   rdaddr  out  B_AW  head entry address
//   rddata  out  B_DW  head entry data
//   rdvld   out  1     FIFO not empty; head entry is valid
//   rdrdy   in   1     consumer accepts the head entry
//
// EAR and S are kept only so existing instantiations still compile. Reset is
// always asynchronous, and no synchronizer stages are needed with one clock.
// EDBG is kept for the same reason; write/read tracing stays in the
// simulation environment and is not part of this synthesizable build.
//------------------------------------------------------------------------------
module powlib_busfifo
    import powlib_busfifo_pkg::*;
#(
    parameter string ID   = "BUSFIFO",
    parameter int    EAR  = 0,
    parameter int    EDBG = 0,
    parameter int    NFS  = 0,
    parameter int    D    = 8,
    parameter int    S    = 0,
    parameter int    B_AW = 32,
    parameter int    B_DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [B_AW-1:0] wraddr,
    input  logic [B_DW-1:0] wrdata,
    input  logic            wrvld,
    output logic            wrrdy,
    output logic            wrnf,
    output logic [B_AW-1:0] rdaddr,
    output logic [B_DW-1:0] rddata,
    output logic            rdvld,
    input  logic            rdrdy
);

    localparam int W  = B_AW + B_DW;
    localparam int PW = powlib_clogb2(D);
    localparam int CW = powlib_clogb2(D + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(D);
    localparam logic [CW-1:0] NFS_C   = CW'(NFS);
    localparam logic [PW-1:0] LAST_C  = PW'(D - 1);

    // If the nearly-full slack is not below the depth, the nearly-full flag
    // would always be set. A single-entry FIFO cannot hold a word while the
    // next one is being written. Both cases stop the build.
    if (NFS >= D || D < 2) begin : g_cfg_error
        $error("%s: invalid configuration NFS=%0d D=%0d (need D >= 2 and NFS < D)",
               ID, NFS, D);
    end

    logic          unused_cfg;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_acc;
    logic          rd_acc;
    logic [W-1:0]  head;

    assign unused_cfg = (EAR != 0) ^ (EDBG != 0) ^ (S != 0);

    // All flags come only from the registered count. The input handshakes
    // do not change them in the same cycle. Because of this, a full FIFO
    // refuses a write even when a pop happens in that cycle.
    assign wrrdy = (count != DEPTH_C);
    assign rdvld = (count != '0);
    assign wrnf  = ((DEPTH_C - count) <= NFS_C);

    assign wr_acc = wrvld && wrrdy;
    assign rd_acc = rdvld && rdrdy;

    // Write pointer. It moves on every accepted write and wraps from D-1
    // to 0, so the depth does not need to be a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
        end else if (wr_acc) begin
            wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Read pointer. It moves on every accepted pop and wraps the same way as
    // the write pointer. The RAM read is asynchronous, so the new head is
    // visible right after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
        end else if (rd_acc) begin
            rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy count. A write and a read in the same cycle cancel out.
    // Reset clears the count at once, so every stored entry is discarded
    // even mid-stream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage. All write-enable bits are tied to the write accept, so a
    // refused or idle cycle never changes the RAM. The address is packed
    // above the data in each word.
    powlib_dpram #(
        .ID ({ID, "_DPRAM"}),
        .W  (W),
        .D  (D),
        .AW (PW)
    ) u_dpram (
        .clk    (clk),
        .wraddr (wr_ptr),
        .wrdata ({wraddr, wrdata}),
        .wrbe   ({W{wr_acc}}),
        .rdaddr (rd_ptr),
        .rddata (head)
    );

    assign rdaddr = head[W-1 -: B_AW];
    assign rddata = head[B_DW-1:0];

endmodule : powlib_busfifo

// File: tb/tb_powlib_busfifo.sv
//------------------------------------------------------------------------------
// tb_powlib_busfifo
//
// Self-checking bench for powlib_busfifo with D=8, NFS=3, 8-bit address and
// 8-bit data. A table of hand-computed vectors covers single-entry, fill and
// drain behaviour. Hand-written sequences cover simultaneous push/pop, a full
// FIFO with a same-cycle pop, a randomized stream, and reset mid-stream.
//------------------------------------------------------------------------------
module tb_powlib_busfifo;

    localparam int D   = 8;
    localparam int NFS = 3;
    localparam int AW  = 8;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata;
    logic          wrvld;
    logic          wrrdy;
    logic          wrnf;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rddata;
    logic          rdvld;
    logic          rdrdy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       wv;
        logic [7:0] a;
        logic [7:0] d;
        logic       rr;
        logic       e_rdy;
        logic       e_nf;
        logic       e_vld;
        logic       chk_head;
        logic [7:0] e_a;
        logic [7:0] e_d;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb[$];

    powlib_busfifo #(
        .ID   ("TBFIFO"),
        .EAR  (0),
        .EDBG (0),
        .NFS  (NFS),
        .D    (D),
        .S    (0),
        .B_AW (AW),
        .B_DW (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wraddr (wraddr),
        .wrdata (wrdata),
        .wrvld  (wrvld),
        .wrrdy  (wrrdy),
        .wrnf   (wrnf),
        .rdaddr (rdaddr),
        .rddata (rddata),
        .rdvld  (rdvld),
        .rdrdy  (rdrdy)
    );

    always #5 clk = ~clk;

    // Stops the run if anything hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wv, input logic [7:0] a,
                                 input logic [7:0] d, input logic rr);
        wrvld  = wv;
        wraddr = a;
        wrdata = d;
        rdrdy  = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add_vec(input logic wv, input logic [7:0] a,
                                    input logic [7:0] d, input logic rr,
                                    input logic e_rdy, input logic e_nf,
                                    input logic e_vld, input logic chk,
                                    input logic [7:0] e_a, input logic [7:0] e_d);
        vec_t v;
        v.wv = wv; v.a = a; v.d = d; v.rr = rr;
        v.e_rdy = e_rdy; v.e_nf = e_nf; v.e_vld = e_vld;
        v.chk_head = chk; v.e_a = e_a; v.e_d = e_d;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] exp_head;
        int sent;
        int got;
        int cycles;
        logic wv;
        logic rr;

        // Table: each vector gives the inputs for one cycle. It also gives
        // the outputs expected before that cycle's edge.
        // Single entry: write, hold for three cycles, pop.
        add_vec(1, 8'h12, 8'h34, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add_vec(0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h12, 8'h34);
        add_vec(0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h12, 8'h34);
        add_vec(0, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h12, 8'h34);
        add_vec(0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h12, 8'h34);
        // Fill with data 0..8 and no reads. The ninth write is dropped.
        add_vec(1, 8'h80, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00);
        add_vec(1, 8'h81, 8'h01, 0, 1, 0, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h82, 8'h02, 0, 1, 0, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h83, 8'h03, 0, 1, 0, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h84, 8'h04, 0, 1, 0, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h85, 8'h05, 0, 1, 1, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h86, 8'h06, 0, 1, 1, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h87, 8'h07, 0, 1, 1, 1, 1, 8'h80, 8'h00);
        add_vec(1, 8'h88, 8'h08, 0, 0, 1, 1, 1, 8'h80, 8'h00);
        // Drain in order.
        add_vec(0, 8'h00, 8'h00, 1, 0, 1, 1, 1, 8'h80, 8'h00);
        add_vec(0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h81, 8'h01);
        add_vec(0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h82, 8'h02);
        add_vec(0, 8'h00, 8'h00, 1, 1, 1, 1, 1, 8'h83, 8'h03);
        add_vec(0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h84, 8'h04);
        add_vec(0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h85, 8'h05);
        add_vec(0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h86, 8'h06);
        add_vec(0, 8'h00, 8'h00, 1, 1, 0, 1, 1, 8'h87, 8'h07);
        add_vec(0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 8'h00, 8'h00);

        // Reset is held while a write is requested.
        rst = 1'b0;
        applyStimulus(1, 8'hEE, 8'hEE, 0);
        repeat (3) tick();
        checkOutput("reset_wrrdy", 32'(wrrdy), 32'd1);
        checkOutput("reset_wrnf", 32'(wrnf), 32'd0);
        checkOutput("reset_rdvld", 32'(rdvld), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 0);
        tick();
        checkOutput("reset_no_entry", 32'(rdvld), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            checkOutput($sformatf("vec%0d_wrrdy", i), 32'(wrrdy), 32'(vecs[i].e_rdy));
            checkOutput($sformatf("vec%0d_wrnf", i), 32'(wrnf), 32'(vecs[i].e_nf));
            checkOutput($sformatf("vec%0d_rdvld", i), 32'(rdvld), 32'(vecs[i].e_vld));
            if (vecs[i].chk_head) begin
                checkOutput($sformatf("vec%0d_head", i), 32'({rdaddr, rddata}),
                            32'({vecs[i].e_a, vecs[i].e_d}));
            end
            applyStimulus(vecs[i].wv, vecs[i].a, vecs[i].d, vecs[i].rr);
            tick();
        end

        // Simultaneous push and pop at count 4, across the pointer wrap.
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'(8'h40 + i), 8'(8'hA0 + i), 0);
            sb.push_back({8'(8'h40 + i), 8'(8'hA0 + i)});
            tick();
        end
        for (int i = 4; i < 14; i++) begin
            checkOutput($sformatf("sim4_rdvld_%0d", i), 32'(rdvld), 32'd1);
            checkOutput($sformatf("sim4_wrrdy_%0d", i), 32'(wrrdy), 32'd1);
            checkOutput($sformatf("sim4_wrnf_%0d", i), 32'(wrnf), 32'd0);
            exp_head = sb.pop_front();
            checkOutput($sformatf("sim4_head_%0d", i), 32'({rdaddr, rddata}), 32'(exp_head));
            applyStimulus(1, 8'(8'h40 + i), 8'(8'hA0 + i), 1);
            sb.push_back({8'(8'h40 + i), 8'(8'hA0 + i)});
            tick();
        end
        applyStimulus(0, 8'h00, 8'h00, 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("sim4_drain_rdvld_%0d", k), 32'(rdvld), 32'd1);
            exp_head = sb.pop_front();
            checkOutput($sformatf("sim4_drain_head_%0d", k), 32'({rdaddr, rddata}),
                        32'(exp_head));
            tick();
        end
        checkOutput("sim4_empty", 32'(rdvld), 32'd0);

        // A full FIFO refuses a write even when a pop happens in that cycle.
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'(8'h60 + i), 8'(8'hB0 + i), 0);
            sb.push_back({8'(8'h60 + i), 8'(8'hB0 + i)});
            tick();
        end
        checkOutput("full_wrrdy", 32'(wrrdy), 32'd0);
        applyStimulus(1, 8'hFF, 8'hFF, 1);
        exp_head = sb.pop_front();
        checkOutput("full_sim_head", 32'({rdaddr, rddata}), 32'(exp_head));
        tick();
        checkOutput("full_sim_wrrdy_after", 32'(wrrdy), 32'd1);
        checkOutput("full_sim_wrnf_after", 32'(wrnf), 32'd1);
        applyStimulus(0, 8'h00, 8'h00, 1);
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("full_drain_rdvld_%0d", k), 32'(rdvld), 32'd1);
            exp_head = sb.pop_front();
            checkOutput($sformatf("full_drain_head_%0d", k), 32'({rdaddr, rddata}),
                        32'(exp_head));
            tick();
        end
        checkOutput("full_drain_empty", 32'(rdvld), 32'd0);

        // Stream of 20 entries with random handshakes, checked in order.
        sb.delete();
        sent = 0;
        got = 0;
        cycles = 0;
        while (got < 20 && cycles < 2000) begin
            wv = (sent < 20) && ($urandom_range(0, 1) == 1);
            rr = ($urandom_range(0, 1) == 1);
            applyStimulus(wv, 8'(8'h10 + sent), 8'(sent * 7 + 3), rr);
            if (rdvld && rr) begin
                if (sb.size() == 0) begin
                    checkOutput("stream_unexpected_pop", 32'(rdvld), 32'd0);
                end else begin
                    exp_head = sb.pop_front();
                    checkOutput($sformatf("stream_head_%0d", got), 32'({rdaddr, rddata}),
                                32'(exp_head));
                end
                got++;
            end
            if (wv && wrrdy) begin
                sb.push_back({8'(8'h10 + sent), 8'(sent * 7 + 3)});
                sent++;
            end
            cycles++;
            tick();
        end
        checkOutput("stream_completed", 32'(got), 32'd20);
        applyStimulus(0, 8'h00, 8'h00, 0);
        tick();
        checkOutput("stream_empty", 32'(rdvld), 32'd0);

        // Reset mid-stream discards every entry at once.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'(8'h70 + i), 8'(8'hD0 + i), 0);
            tick();
        end
        applyStimulus(0, 8'h00, 8'h00, 0);
        checkOutput("midreset_pre_rdvld", 32'(rdvld), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_rdvld", 32'(rdvld), 32'd0);
        checkOutput("midreset_wrrdy", 32'(wrrdy), 32'd1);
        checkOutput("midreset_wrnf", 32'(wrnf), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        applyStimulus(1, 8'h5A, 8'hC3, 0);
        tick();
        applyStimulus(0, 8'h00, 8'h00, 1);
        checkOutput("postreset_rdvld", 32'(rdvld), 32'd1);
        checkOutput("postreset_head", 32'({rdaddr, rddata}), 32'h5AC3);
        tick();
        checkOutput("postreset_only_entry", 32'(rdvld), 32'd0);
        applyStimulus(0, 8'h00, 8'h00, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_powlib_busfifo
